// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small word FIFO in front of it.
// One 8-bit frame at a time: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_fifo #(
    parameter int CLK_DIV    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       txclk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_empty,
    output logic [4:0] fifo_count,
    output logic [2:0] state_dbg
);

    localparam int         AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [15:0] BIT_RELOAD = 16'(CLK_DIV - 1);
    localparam logic [4:0]  DEPTH_C    = 5'(FIFO_DEPTH);
    localparam logic [2:0]  STOP_LAST  = 3'(STOP_BITS - 1);
    localparam logic        PAR_EN_C   = (PARITY_EN != 0);
    localparam logic        ODD_C      = (PARITY_ODD != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;

    logic [2:0]  state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_q, parity_d;
    logic        tx_out_q, tx_out_d;

    logic       push;
    logic       pop;
    logic       start_frame;
    logic       bit_done;
    logic       fifo_nonempty;
    logic [7:0] head_word;

    // Ready depends only on the stored count, so a same-cycle pop never opens a full FIFO.
    assign tx_ready      = (count_q < DEPTH_C);
    assign push          = tx_valid && tx_ready;
    assign fifo_nonempty = (count_q != 5'd0);
    assign head_word     = mem_q[rd_ptr_q];
    assign bit_done      = (timer_q == 16'd0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        tx_out_d    = tx_out_q;
        start_frame = 1'b0;
        pop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_out_d = 1'b1;
                if (fifo_nonempty) begin
                    start_frame = 1'b1;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d   = S_DATA;
                    tx_out_d  = shift_q[0];
                    bit_cnt_d = 3'd0;
                    timer_d   = BIT_RELOAD;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    timer_d = BIT_RELOAD;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
                        if (PAR_EN_C) begin
                            state_d  = S_PARITY;
                            tx_out_d = parity_q;
                        end else begin
                            state_d  = S_STOP;
                            tx_out_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_out_d  = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    state_d   = S_STOP;
                    tx_out_d  = 1'b1;
                    bit_cnt_d = 3'd0;
                    timer_d   = BIT_RELOAD;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_STOP: begin
                tx_out_d = 1'b1;
                if (bit_done) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = 3'd0;
                        if (fifo_nonempty) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            timer_d = 16'd0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        timer_d   = BIT_RELOAD;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                tx_out_d = 1'b1;
                timer_d  = 16'd0;
            end
        endcase

        // Shared by IDLE and the end of STOP so back-to-back frames have no idle gap.
        if (start_frame) begin
            pop       = 1'b1;
            shift_d   = head_word;
            parity_d  = (^head_word) ^ ODD_C;
            state_d   = S_START;
            tx_out_d  = 1'b0;
            timer_d   = BIT_RELOAD;
            bit_cnt_d = 3'd0;
        end
    end

    always_ff @(posedge txclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= 5'd0;
            state_q   <= S_IDLE;
            timer_q   <= 16'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            parity_q  <= 1'b0;
            tx_out_q  <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_out_q  <= tx_out_d;
        end
    end

    assign tx_out     = tx_out_q;
    assign tx_busy    = (state_q != S_IDLE);
    assign tx_empty   = (count_q == 5'd0) && !tx_busy;
    assign fifo_count = count_q;
    assign state_dbg  = state_q;

endmodule
